// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a single-port 1024x32 SRAM macro.
// A push stream and a pop stream are turned into at most one SRAM access
// per cycle. A two-entry output buffer hides the one-cycle read latency.
// Reads take priority over writes. A read is only issued while the output
// buffer plus the read in flight can still hold another word, so the push
// side is never starved for long.
module sram_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              UserCLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [DATA_W-1:0] A_DIN,
  output logic [DATA_W-1:0] A_BM,
  output logic              A_WEN,
  output logic              A_MEN,
  output logic              A_REN,
  input  logic [DATA_W-1:0] A_DOUT
);

  // Number of SRAM words, expressed at the width of the SRAM word counter.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   sram_cnt_q, sram_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic [DATA_W-1:0] ob0_q, ob0_d;
  logic [DATA_W-1:0] ob1_q, ob1_d;
  logic [1:0]        ob_cnt_q, ob_cnt_d;

  logic              pop_now;
  logic              rd_issue;
  logic              wr_issue;
  logic [2:0]        ob_occ;

  // Head of the output buffer is the user-visible word.
  assign out_valid = (ob_cnt_q != 2'd0);
  assign out_data  = ob0_q;
  assign pop_now   = out_valid && out_ready;
  assign full      = (sram_cnt_q == DEPTH_C);

  // Output-buffer slots still claimed after this cycle's pop, counting the read in flight.
  assign ob_occ   = {1'b0, ob_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop_now};
  assign rd_issue = (sram_cnt_q != '0) && (ob_occ < 3'd2);
  assign in_ready = !RST && !full && !rd_issue;
  assign wr_issue = in_valid && in_ready;

  // The occupancy seen by the user includes the word in flight from the SRAM.
  assign count = {1'b0, sram_cnt_q}
               + {{(ADDR_W + 1){1'b0}}, rd_inflight_q}
               + {{ADDR_W{1'b0}}, ob_cnt_q};
  assign empty = (count == '0);

  // SRAM port: a read, a write or nothing. The SRAM samples these signals at the next edge.
  always_comb begin
    A_MEN  = rd_issue || wr_issue;
    A_REN  = rd_issue;
    A_WEN  = wr_issue;
    A_ADDR = wr_issue ? wr_ptr_q : rd_ptr_q;
    A_DIN  = RST ? '0 : in_data;
    A_BM   = wr_issue ? '1 : '0;
  end

  // Next state: pointers, SRAM occupancy, and output buffer pop/shift then capture/append.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sram_cnt_d    = sram_cnt_q;
    rd_inflight_d = rd_issue;
    ob0_d         = ob0_q;
    ob1_d         = ob1_q;
    ob_cnt_d      = ob_cnt_q;

    if (wr_issue) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q + 1'b1;
    end else if (rd_issue) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q - 1'b1;
    end

    if (pop_now) begin
      ob0_d    = ob1_q;
      ob_cnt_d = ob_cnt_q - 2'd1;
    end

    // Returning read data goes behind whatever is left after the pop.
    if (rd_inflight_q) begin
      if (ob_cnt_d == 2'd0) begin
        ob0_d = A_DOUT;
      end else begin
        ob1_d = A_DOUT;
      end
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
  end

  // State registers with asynchronous clear. SRAM contents are left as they are.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sram_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      ob0_q         <= '0;
      ob1_q         <= '0;
      ob_cnt_q      <= 2'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sram_cnt_q    <= sram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      ob0_q         <= ob0_d;
      ob1_q         <= ob1_d;
      ob_cnt_q      <= ob_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl.
// A behavioural SRAM model is attached to the controller. Accepted pushes go
// into a scoreboard queue, and a monitor checks every pop against that queue.
// Push and pop totals give the expected count and the SRAM addresses used.
module tb_sram_fifo_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W+1:0] count;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DIN;
  logic [DATA_W-1:0] A_BM;
  logic              A_WEN;
  logic              A_MEN;
  logic              A_REN;
  logic [DATA_W-1:0] A_DOUT = '0;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard state, derived only from observed handshakes.
  logic [DATA_W-1:0] sb[$];
  int model_cnt = 0;
  int wr_addr_m = 0;
  int rd_addr_m = 0;

  logic [DATA_W-1:0] sram_mem [DEPTH];

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .UserCLK  (clk),
    .RST      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .A_ADDR   (A_ADDR),
    .A_DIN    (A_DIN),
    .A_BM     (A_BM),
    .A_WEN    (A_WEN),
    .A_MEN    (A_MEN),
    .A_REN    (A_REN),
    .A_DOUT   (A_DOUT)
  );

  // Single-port SRAM behaviour: bit-masked write, registered read data.
  always @(posedge clk) begin
    if (A_MEN) begin
      if (A_WEN) sram_mem[A_ADDR] <= (sram_mem[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
      if (A_REN) A_DOUT <= sram_mem[A_ADDR];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, so the handshakes seen here are the ones taken at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_status", {out_valid, count, empty, full, in_ready, A_MEN, A_WEN, A_REN},
          {1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 3'b000});
      chk("reset_bus", {A_ADDR, A_DIN}, 64'd0);
      chk("reset_bm_data", {A_BM, out_data}, 64'd0);
      sb.delete();
      model_cnt = 0;
      wr_addr_m = 0;
      rd_addr_m = 0;
    end else begin
      chk("count", 64'(count), 64'(model_cnt));
      chk("empty", 64'(empty), 64'(model_cnt == 0));
      if (A_WEN && A_REN) chk("wen_ren_exclusive", 64'(2'b11), 64'(2'b01));
      chk("men_consistent", 64'(A_MEN), 64'(A_WEN | A_REN));
      chk("wen_is_push", 64'(A_WEN), 64'(in_valid && in_ready));
      if (A_MEN && A_WEN) begin
        chk("wr_addr", 64'(A_ADDR), 64'(wr_addr_m % DEPTH));
        chk("wr_bm_din", {A_BM, A_DIN}, {32'hFFFF_FFFF, in_data});
        wr_addr_m++;
      end
      if (A_MEN && A_REN) begin
        chk("rd_addr", 64'(A_ADDR), 64'(rd_addr_m % DEPTH));
        rd_addr_m++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        model_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          chk("pop_data", 64'(out_data), 64'(sb.pop_front()));
        end
        model_cnt--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the word is accepted, giving up after a bounded wait.
  task automatic push_word(input logic [DATA_W-1:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = empty;
      if (!done) step();
    end
    step();
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset, then idle.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_status", {out_valid, empty, A_MEN, in_ready}, {1'b0, 1'b1, 1'b0, 1'b1});
      step();
    end

    // A single push: write, then read, then output two cycles after acceptance.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_0001;
    @(negedge clk);
    chk("single_wr", {in_ready, A_WEN, A_REN, A_ADDR}, {1'b1, 1'b1, 1'b0, 10'd0});
    chk("single_bm", 64'(A_BM), 64'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_rd", {A_REN, A_WEN, A_ADDR, out_valid}, {1'b1, 1'b0, 10'd0, 1'b0});
    step();
    @(negedge clk);
    chk("single_lat1", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    chk("single_out", {out_valid, out_data}, {1'b1, 32'hA5A5_0001});
    step();
    @(negedge clk);
    chk("single_count0", {count, empty}, {12'd0, 1'b1});
    step();

    // Fill to capacity with no pops.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) push_word(DATA_W'(i));
    repeat (3) step();
    @(negedge clk);
    chk("fill_count", 64'(count), 64'(DEPTH + 2));
    chk("fill_full", {full, in_ready}, {1'b1, 1'b0});
    step();
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      chk("full_push_blocked", {in_ready, A_WEN}, 2'b00);
      step();
    end
    in_valid = 1'b0;
    drain(3000);

    // Sustained streaming, enough to wrap both pointers.
    out_ready = 1'b1;
    for (int i = 0; i < 3000; i++) push_word(32'h5000_0000 + DATA_W'(i));
    drain(100);
    chk("stream_wrapped", 64'(wr_addr_m >= 3000 && rd_addr_m >= 3000), 64'd1);

    // Reset in the middle of traffic.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h7700_0000 + DATA_W'(i));
    out_ready = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_enables", {A_MEN, A_WEN, A_REN, out_valid}, 4'b0000);
    chk("midrst_count", 64'(count), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    push_word(32'h0000_1234);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          chk("post_rst_first", 64'(out_data), 64'h1234);
        end
        step();
      end
      if (!seen) chk("post_rst_timeout", 64'd0, 64'd1);
    end
    drain(20);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 50);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 99) < 30);
      step();
    end
    in_valid = 1'b0;
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
